// File: rtl/cond_branch_unit.sv
// Condition-code capture, branch-enable evaluation and a 2-bit
// saturating branch predictor feeding the mispredict flag.
//
// Ports:
//   Clk, Reset_n        : clock, asynchronous active-low reset
//   Bus_In, Carry_In,   : ALU result and its carry/overflow flags
//   Ovf_In
//   CC_Sel, LOAD_CC     : condition-code set select and load strobe
//   Cond, LOAD_BEN      : {N,Z,P,C,V} test mask and evaluate strobe
//   Pred_Idx            : predictor entry for lookup and update
//   BEN_out, BEN_valid  : registered branch enable and its strobe
//   Mispredict          : last evaluation disagreed with prediction
//   Pred_Taken          : combinational prediction for Pred_Idx
//   CC_out              : stored {N,Z,P,C,V} of the selected set
module cond_branch_unit #(
    parameter int WIDTH      = 16,
    parameter int NUM_CC     = 2,
    parameter int PRED_DEPTH = 8
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    input  logic [WIDTH-1:0]     Bus_In,
    input  logic                 Carry_In,
    input  logic                 Ovf_In,
    input  logic [((NUM_CC > 1) ? $clog2(NUM_CC) : 1)-1:0] CC_Sel,
    input  logic                 LOAD_CC,
    input  logic [4:0]           Cond,
    input  logic                 LOAD_BEN,
    input  logic [$clog2(PRED_DEPTH)-1:0] Pred_Idx,
    output logic                 BEN_out,
    output logic                 BEN_valid,
    output logic                 Mispredict,
    output logic                 Pred_Taken,
    output logic [4:0]           CC_out
);

    localparam logic [4:0] CC_RESET = 5'b01000;

    logic [4:0] cc_q  [NUM_CC];
    logic [1:0] ctr_q [PRED_DEPTH];

    logic       sel_ok;
    logic       flag_n;
    logic       flag_z;
    logic       flag_p;
    logic [4:0] flags;
    logic [4:0] cc_rd;
    logic       ben_in;
    logic [1:0] ctr_rd;

    // Non-power-of-two set counts leave select codes with no set behind them.
    assign sel_ok = int'(CC_Sel) < NUM_CC;

    assign flag_n = Bus_In[WIDTH-1];
    assign flag_z = ~|Bus_In;
    assign flag_p = ~flag_n & ~flag_z;
    assign flags  = {flag_n, flag_z, flag_p, Carry_In, Ovf_In};

    always_comb begin
        cc_rd = 5'b00000;
        if (sel_ok) begin
            cc_rd = cc_q[CC_Sel];
        end
    end

    assign CC_out = cc_rd;

    // Evaluated from the stored flags, so a same-cycle load is not seen.
    assign ben_in = |(Cond & cc_rd);

    assign ctr_rd     = ctr_q[Pred_Idx];
    assign Pred_Taken = ctr_rd[1];

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < NUM_CC; i++) begin
                cc_q[i] <= CC_RESET;
            end
        end else if (LOAD_CC && sel_ok) begin
            cc_q[CC_Sel] <= flags;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < PRED_DEPTH; i++) begin
                ctr_q[i] <= 2'd1;
            end
        end else if (LOAD_BEN) begin
            if (ben_in && ctr_rd != 2'd3) begin
                ctr_q[Pred_Idx] <= ctr_rd + 2'd1;
            end else if (!ben_in && ctr_rd != 2'd0) begin
                ctr_q[Pred_Idx] <= ctr_rd - 2'd1;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            BEN_out    <= 1'b0;
            BEN_valid  <= 1'b0;
            Mispredict <= 1'b0;
        end else begin
            BEN_valid <= LOAD_BEN;
            if (LOAD_BEN) begin
                BEN_out    <= ben_in;
                Mispredict <= ben_in != Pred_Taken;
            end
        end
    end

endmodule

// File: tb/tb_cond_branch_unit.sv
// Directed self-checking bench for cond_branch_unit
// (WIDTH=16, NUM_CC=2, PRED_DEPTH=8).
`timescale 1ns/1ps
module tb_cond_branch_unit;

    logic        Clk;
    logic        Reset_n;
    logic [15:0] Bus_In;
    logic        Carry_In;
    logic        Ovf_In;
    logic [0:0]  CC_Sel;
    logic        LOAD_CC;
    logic [4:0]  Cond;
    logic        LOAD_BEN;
    logic [2:0]  Pred_Idx;
    logic        BEN_out;
    logic        BEN_valid;
    logic        Mispredict;
    logic        Pred_Taken;
    logic [4:0]  CC_out;

    int checks = 0;
    int errors = 0;

    cond_branch_unit #(
        .WIDTH(16),
        .NUM_CC(2),
        .PRED_DEPTH(8)
    ) dut (
        .Clk(Clk),
        .Reset_n(Reset_n),
        .Bus_In(Bus_In),
        .Carry_In(Carry_In),
        .Ovf_In(Ovf_In),
        .CC_Sel(CC_Sel),
        .LOAD_CC(LOAD_CC),
        .Cond(Cond),
        .LOAD_BEN(LOAD_BEN),
        .Pred_Idx(Pred_Idx),
        .BEN_out(BEN_out),
        .BEN_valid(BEN_valid),
        .Mispredict(Mispredict),
        .Pred_Taken(Pred_Taken),
        .CC_out(CC_out)
    );

    initial begin
        Clk = 1'b0;
        forever #10 Clk = ~Clk;
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        LOAD_CC  = 1'b0;
        LOAD_BEN = 1'b0;
        Carry_In = 1'b0;
        Ovf_In   = 1'b0;
    endtask

    task automatic load_cc(input logic [0:0] sel, input logic [15:0] v,
                           input logic c, input logic o);
        CC_Sel = sel; Bus_In = v; Carry_In = c; Ovf_In = o;
        LOAD_CC = 1'b1;
        tick();
        idle();
        #1;
    endtask

    task automatic test_reset();
        load_cc(1'b0, 16'h8000, 1'b1, 1'b0);
        Pred_Idx = 3'd0; Cond = 5'b10000; LOAD_BEN = 1'b1;
        tick(); tick();
        idle();
        #1;
        checks++;
        if (BEN_out !== 1'b1) begin
            $display("FAIL pre_reset_ben got %b want 1", BEN_out); errors++;
        end
        Reset_n = 1'b0;
        #1;
        CC_Sel = 1'b0;
        #1;
        checks++;
        if (CC_out !== 5'b01000) begin
            $display("FAIL rst_cc0 got %b want 01000", CC_out); errors++;
        end
        CC_Sel = 1'b1;
        #1;
        checks++;
        if (CC_out !== 5'b01000) begin
            $display("FAIL rst_cc1 got %b want 01000", CC_out); errors++;
        end
        checks++;
        if ({BEN_out, BEN_valid, Mispredict} !== 3'b000) begin
            $display("FAIL rst_outs got %b want 000",
                     {BEN_out, BEN_valid, Mispredict});
            errors++;
        end
        for (int i = 0; i < 8; i++) begin
            Pred_Idx = 3'(i);
            #0.5;
            checks++;
            if (Pred_Taken !== 1'b0) begin
                $display("FAIL rst_pred idx %0d got %b want 0", i, Pred_Taken);
                errors++;
            end
        end
        // strobes while in reset are dropped
        CC_Sel = 1'b0; Bus_In = 16'h8000; LOAD_CC = 1'b1;
        Pred_Idx = 3'd0; Cond = 5'b01000; LOAD_BEN = 1'b1;
        tick();
        checks++;
        if (CC_out !== 5'b01000 || BEN_valid !== 1'b0) begin
            $display("FAIL rst_discard got cc %b v %b want 01000 0",
                     CC_out, BEN_valid);
            errors++;
        end
        idle();
        Reset_n = 1'b1;
        tick();
        checks++;
        if (CC_out !== 5'b01000 || BEN_valid !== 1'b0 || Pred_Taken !== 1'b0) begin
            $display("FAIL rst_release got cc %b v %b p %b want 01000 0 0",
                     CC_out, BEN_valid, Pred_Taken);
            errors++;
        end
    endtask

    task automatic test_flag_capture();
        logic [15:0] bus_v [3];
        logic        c_v   [3];
        logic        o_v   [3];
        logic [4:0]  exp_v [3];
        bus_v = '{16'h8000, 16'h0000, 16'h7FFF};
        c_v   = '{1'b1, 1'b0, 1'b0};
        o_v   = '{1'b0, 1'b0, 1'b1};
        exp_v = '{5'b10010, 5'b01000, 5'b00101};
        for (int i = 0; i < 3; i++) begin
            load_cc(1'b0, bus_v[i], c_v[i], o_v[i]);
            CC_Sel = 1'b0;
            #1;
            checks++;
            if (CC_out !== exp_v[i]) begin
                $display("FAIL cap_set0 step %0d got %b want %b",
                         i, CC_out, exp_v[i]);
                errors++;
            end
            CC_Sel = 1'b1;
            #1;
            checks++;
            if (CC_out !== 5'b01000) begin
                $display("FAIL cap_set1 step %0d got %b want 01000", i, CC_out);
                errors++;
            end
        end
    endtask

    task automatic test_hazard();
        load_cc(1'b0, 16'h0000, 1'b0, 1'b0);
        // idx 5 at 1: predicts not taken
        CC_Sel = 1'b0; Bus_In = 16'h0005; LOAD_CC = 1'b1;
        Cond = 5'b01000; Pred_Idx = 3'd5; LOAD_BEN = 1'b1;
        tick();
        idle();
        #1;
        checks++;
        if ({BEN_out, BEN_valid, Mispredict} !== 3'b111) begin
            $display("FAIL hz_first got %b want 111",
                     {BEN_out, BEN_valid, Mispredict});
            errors++;
        end
        checks++;
        if (CC_out !== 5'b00100) begin
            $display("FAIL hz_cc got %b want 00100", CC_out); errors++;
        end
        // hold with no strobe
        tick();
        checks++;
        if ({BEN_out, BEN_valid, Mispredict} !== 3'b101) begin
            $display("FAIL hz_hold got %b want 101",
                     {BEN_out, BEN_valid, Mispredict});
            errors++;
        end
        // idx 5 now 2 predicts taken, result not taken
        LOAD_BEN = 1'b1;
        tick();
        idle();
        #1;
        checks++;
        if ({BEN_out, BEN_valid, Mispredict} !== 3'b011) begin
            $display("FAIL hz_second got %b want 011",
                     {BEN_out, BEN_valid, Mispredict});
            errors++;
        end
    endtask

    task automatic test_predictor();
        logic mis_t [4];
        logic mis_n [4];
        logic pt_n  [4];
        mis_t = '{1'b1, 1'b0, 1'b0, 1'b0};
        mis_n = '{1'b1, 1'b1, 1'b0, 1'b0};
        pt_n  = '{1'b1, 1'b0, 1'b0, 1'b0};
        load_cc(1'b0, 16'h0000, 1'b0, 1'b0);
        CC_Sel = 1'b0; Pred_Idx = 3'd3;
        for (int i = 0; i < 4; i++) begin
            Cond = 5'b01000; LOAD_BEN = 1'b1;
            if (i == 0) begin
                #1;
                checks++;
                if (Pred_Taken !== 1'b0) begin
                    $display("FAIL pr_pre got %b want 0", Pred_Taken); errors++;
                end
            end
            tick();
            LOAD_BEN = 1'b0;
            #1;
            checks++;
            if (Mispredict !== mis_t[i] || Pred_Taken !== 1'b1 || BEN_out !== 1'b1) begin
                $display("FAIL pr_taken %0d got m %b p %b b %b want %b 1 1",
                         i, Mispredict, Pred_Taken, BEN_out, mis_t[i]);
                errors++;
            end
        end
        for (int i = 0; i < 4; i++) begin
            Cond = 5'b10000; LOAD_BEN = 1'b1;
            tick();
            LOAD_BEN = 1'b0;
            #1;
            checks++;
            if (Mispredict !== mis_n[i] || Pred_Taken !== pt_n[i] || BEN_out !== 1'b0) begin
                $display("FAIL pr_not %0d got m %b p %b b %b want %b %b 0",
                         i, Mispredict, Pred_Taken, BEN_out, mis_n[i], pt_n[i]);
                errors++;
            end
        end
        // from 0, one taken lands on 1: still predicts not taken
        Cond = 5'b01000; LOAD_BEN = 1'b1;
        tick();
        LOAD_BEN = 1'b0;
        #1;
        checks++;
        if (Mispredict !== 1'b1 || Pred_Taken !== 1'b0) begin
            $display("FAIL pr_floor got m %b p %b want 1 0", Mispredict, Pred_Taken);
            errors++;
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] cnd [4];
        logic       ben [4];
        cnd = '{5'b01000, 5'b10000, 5'b01000, 5'b10000};
        ben = '{1'b1, 1'b0, 1'b1, 1'b0};
        CC_Sel = 1'b0; Pred_Idx = 3'd6;
        for (int i = 0; i < 4; i++) begin
            Cond = cnd[i]; LOAD_BEN = 1'b1;
            tick();
            checks++;
            if (BEN_valid !== 1'b1 || BEN_out !== ben[i] || Mispredict !== 1'b1) begin
                $display("FAIL b2b %0d got v %b b %b m %b want 1 %b 1",
                         i, BEN_valid, BEN_out, Mispredict, ben[i]);
                errors++;
            end
        end
        LOAD_BEN = 1'b0;
        tick();
        checks++;
        if (BEN_valid !== 1'b0 || BEN_out !== 1'b0) begin
            $display("FAIL b2b_end got v %b b %b want 0 0", BEN_valid, BEN_out);
            errors++;
        end
    endtask

    task automatic test_mid_reset();
        CC_Sel = 1'b0; Pred_Idx = 3'd2; Cond = 5'b01000; LOAD_BEN = 1'b1;
        tick(); tick(); tick();
        LOAD_BEN = 1'b0;
        #1;
        checks++;
        if (BEN_valid !== 1'b1 || BEN_out !== 1'b1 || Pred_Taken !== 1'b1) begin
            $display("FAIL mr_pre got v %b b %b p %b want 1 1 1",
                     BEN_valid, BEN_out, Pred_Taken);
            errors++;
        end
        Reset_n = 1'b0;
        #1;
        checks++;
        if (BEN_valid !== 1'b0 || BEN_out !== 1'b0 || Pred_Taken !== 1'b0) begin
            $display("FAIL mr_async got v %b b %b p %b want 0 0 0",
                     BEN_valid, BEN_out, Pred_Taken);
            errors++;
        end
        tick();
        Reset_n = 1'b1;
        tick();
        checks++;
        if (BEN_valid !== 1'b0 || Pred_Taken !== 1'b0) begin
            $display("FAIL mr_release got v %b p %b want 0 0", BEN_valid, Pred_Taken);
            errors++;
        end
        // one taken from the reset value of 1 reaches 2
        LOAD_BEN = 1'b1;
        tick();
        LOAD_BEN = 1'b0;
        #1;
        checks++;
        if (BEN_valid !== 1'b1 || Mispredict !== 1'b1 || Pred_Taken !== 1'b1) begin
            $display("FAIL mr_after got v %b m %b p %b want 1 1 1",
                     BEN_valid, Mispredict, Pred_Taken);
            errors++;
        end
    endtask

    initial begin
        Reset_n  = 1'b0;
        Bus_In   = '0;
        CC_Sel   = '0;
        Cond     = '0;
        Pred_Idx = '0;
        idle();
        tick(); tick();
        Reset_n = 1'b1;
        tick();
        test_reset();
        test_flag_capture();
        test_hazard();
        test_predictor();
        test_back_to_back();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cond_branch_unit.md
COND_BRANCH_UNIT -- requirements
Module: cond_branch_unit

Interface
REQ-001 Parameter WIDTH, default 16: data-bus width; SHALL be at least 2.
REQ-002 Parameter NUM_CC, default 2: number of independent condition-code sets; SHALL be at least 1.
REQ-003 Parameter PRED_DEPTH, default 8: predictor table entries; SHALL be a power of two, at least 2.
REQ-004 Clk  in  1: sole clock; all state SHALL update on its rising edge.
REQ-005 Reset_n  in  1: asynchronous, active-low reset.
REQ-006 Bus_In  in  WIDTH: result value whose flags are captured.
REQ-007 Carry_In, Ovf_In  in  1 each: ALU carry and overflow for the current Bus_In.
REQ-008 CC_Sel  in  max(1,$clog2(NUM_CC)): selects the CC set for load, test and CC_out.
REQ-009 LOAD_CC  in  1: capture flags into the selected CC set.
REQ-010 Cond  in  5: test mask {N,Z,P,C,V}, with MSB=N.
REQ-011 LOAD_BEN  in  1: evaluate the branch condition and update the predictor.
REQ-012 Pred_Idx  in  $clog2(PRED_DEPTH): predictor entry for lookup and update.
REQ-013 BEN_out  out  1: registered branch-enable result.
REQ-014 BEN_valid  out  1: one-cycle pulse marking a new BEN_out.
REQ-015 Mispredict  out  1: registered flag, set when the last evaluation disagreed with the prediction.
REQ-016 Pred_Taken  out  1: combinational prediction for Pred_Idx.
REQ-017 CC_out  out  5: stored {N,Z,P,C,V} of the selected set (combinational read).

Function
REQ-018 Flag derivation SHALL be: N=Bus_In[WIDTH-1]; Z=(Bus_In==0); P=~N&~Z; C=Carry_In; V=Ovf_In.
REQ-019 When LOAD_CC=1, the set at CC_Sel SHALL take the derived flags at the clock edge; other sets SHALL hold.
REQ-020 Stored N, Z and P SHALL be one-hot at all times, including after reset.
REQ-021 If CC_Sel is at or above NUM_CC, LOAD_CC SHALL be ignored and CC_out SHALL read 5'b00000.
REQ-022 The evaluation term SHALL be BEN_in = |(Cond & stored CC[CC_Sel]).
REQ-023 With LOAD_CC and LOAD_BEN in the same cycle on the same set, BEN_in SHALL use the pre-load flags (no forwarding).
REQ-024 On LOAD_BEN=1, at the edge: BEN_out<=BEN_in; BEN_valid<=1; Mispredict<=(BEN_in != Pred_Taken).
REQ-025 When LOAD_BEN=0: BEN_out and Mispredict SHALL hold; BEN_valid<=0.
REQ-026 Latency: one cycle from LOAD_BEN to BEN_out, BEN_valid and Mispredict.
REQ-027 Each predictor entry SHALL be a 2-bit saturating counter (0 strong-NT, 1 weak-NT, 2 weak-T, 3 strong-T).
REQ-028 Pred_Taken SHALL equal counter[Pred_Idx][1].
REQ-029 On LOAD_BEN=1, entry Pred_Idx SHALL increment if BEN_in=1 and decrement if BEN_in=0.
REQ-030 Counters SHALL saturate at 3 on increment and at 0 on decrement, with no wrap.
REQ-031 A same-cycle lookup and update of one entry SHALL return the pre-update value; the new value SHALL be visible the next cycle.
REQ-032 Back-to-back LOAD_BEN SHALL be accepted every cycle; BEN_valid stays high, one result per cycle.

Reset
REQ-033 While Reset_n=0, independent of Clk, every CC set SHALL be NZPCV=01000.
REQ-034 While Reset_n=0, every predictor counter SHALL be 1.
REQ-035 While Reset_n=0: BEN_out=0, BEN_valid=0, Mispredict=0.
REQ-036 A LOAD_CC or LOAD_BEN coincident with Reset_n=0 SHALL be discarded.
REQ-037 Reset asserted mid-sequence SHALL clear any pending result; the first valid result needs a new LOAD_BEN after release.
REQ-038 Reset release SHALL be synchronised externally; this block adds no release synchroniser.

Verification (WIDTH=16, NUM_CC=2, PRED_DEPTH=8)
REQ-039 Reset check: pulse Reset_n low between edges -> CC_out=01000, BEN_out=0, Pred_Taken=0 for all idx, without a clock edge.
REQ-040 Flag capture: LOAD_CC set0, Bus_In=8000, Carry_In=1 -> CC_out=10010. Then Bus_In=0000 -> 01000. Then 7FFF with Ovf_In=1 -> 00101. Set1 stays 01000 throughout.
REQ-041 Same-cycle hazard: set0 holds Z; LOAD_CC(Bus_In=0005) together with LOAD_BEN(Cond=01000) -> BEN_out=1 next cycle. Repeat LOAD_BEN -> BEN_out=0.
REQ-042 Predictor saturation: idx 3, four taken evaluations -> Mispredict 1,0,0,0 and counter 2,3,3,3. Then three not-taken evaluations -> counter 2,1,0 and Pred_Taken 1,0,0.
REQ-043 Streaming: LOAD_BEN held high 4 cycles with alternating Cond -> BEN_valid high 4 cycles, one correct BEN_out per cycle, low the following cycle.
REQ-044 Mid-operation reset: assert Reset_n low the cycle after LOAD_BEN -> BEN_valid and BEN_out drop to 0 immediately, counters return to 1.
